pipe_skid_stage_reg: RTL and testbench
======================================

// Module: pipe_skid_stage_reg
// PURPOSE
//  Generic pipeline stage register with valid/ready handshake, flush and a 2-entry skid buffer.
//  Replaces the hand-written per-stage latches (IF/ID ... IM/IW) with one parametrised block.
//  Callers pack their fields (pc, O, D, control bits, rt, rd) into one data bus.
//  in_ready comes straight from a flop, so back-pressure never forms a combinational path across stages.
// PARAMETERS
//  DATA_W  109  payload width; default = IM/IW bundle (3x32 data + 3 ctrl + 2x5 reg idx)
//  RST_VAL 0    value loaded into both data registers on reset
//  CNT_W   16   width of the stall counter (used only with PIPE_STALL_CNT_EN)
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  flush          in   1       synchronous squash of all held entries
//  in_valid       in   1       upstream has a payload
//  in_ready       out  1       stage can accept; registered
//  in_data        in   DATA_W  upstream payload
//  out_valid      out  1       stage holds a payload
//  out_ready      in   1       downstream accepts
//  out_data       out  DATA_W  head payload; always driven from main_data reg
//  perf_stall_cnt out  CNT_W   present only with PIPE_STALL_CNT_EN
// BEHAVIOUR
//  - Accept = in_valid & in_ready. Emit = out_valid & out_ready. Fields pass bit-exact, no reordering.
//  - State machine over {main_v, skid_v}. in_ready = !skid_v. out_valid = main_v.
//  - EMPTY: accept -> ONE (main <= in).
//  - ONE, accept & emit -> ONE (main <= in).
//  - ONE, accept & !emit -> TWO (skid <= in).
//  - ONE, !accept & emit -> EMPTY.
//  - TWO: in_ready = 0. Emit -> ONE (main <= skid). No emit -> hold.
//  - Latency: 1 cycle from accept in EMPTY to out_valid. Sustained throughput is 1 per cycle.
//  - Data registers load only on a transfer. out_data is stable while out_valid & !out_ready.
//  - flush: next state EMPTY, both valids = 0, in_ready = 1.
//    Flush overrides accept and emit in the same cycle. Data registers are not cleared.
//  - rst: overrides flush. Next cycle: out_valid = 0, in_ready = 1, main = skid = RST_VAL, counter = 0.
//    Applies mid-transfer; in-flight payloads are dropped.
//  - Invalid state {main_v=0, skid_v=1} is unreachable. The RTL must recover to EMPTY if it occurs.
// CONFIGURATION
//  - PIPE_STALL_CNT_EN defined: perf_stall_cnt increments each cycle with out_valid & !out_ready.
//    It saturates at all-ones, is cleared only by rst, and holds its value on flush.
//  - PIPE_STALL_CNT_EN undefined: the port and the counter logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - pipe_pkg holds:
//    - typedef pipe_state_t {EMPTY, ONE, TWO}
//    - IMIW_W and the field offset constants used to pack and unpack stage bundles
//  - Sub-module pipe_sat_counter #(CNT_W) implements the saturating counter. Instantiate it only under the macro.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1, in_data=0x1234.
//     -> out_valid=0, in_ready=1, out_data=RST_VAL.
//  2. Streaming: out_ready=1, in_data 1,2,3,4 on consecutive cycles.
//     -> out_data 1,2,3,4 one cycle later; in_ready stays 1.
//  3. Back-pressure: send A then B with out_ready=0.
//     -> out_data=A, in_ready=0 after B. Then raise out_ready: A, then B, in_ready=1 again.
//  4. Flush in TWO, with flush and accept in the same cycle.
//     -> next cycle out_valid=0, in_ready=1; the accepted payload is discarded.
//  5. rst and flush together while in ONE.
//     -> reset values appear next cycle; the stall counter reads 0.
//  6. PIPE_STALL_CNT_EN with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles.
//     -> perf_stall_cnt=15 (saturated); a flush leaves it at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and bundle layout for pipeline stage registers
// Purpose: stage state encoding plus the IM/IW bundle width and field offsets
//          used by callers to pack/unpack the single stage data bus.
// Ports:   none (package)
package pipe_pkg;

  // State bits are {main_v, skid_v}; 2'b01 is the unreachable/invalid code.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } pipe_state_t;

  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 3;
  localparam int WORD_W    = 32;

  // IM/IW bundle layout, LSB first: rd, rt, ctrl, D, O, pc.
  localparam int RD_LSB   = 0;
  localparam int RT_LSB   = RD_LSB + REG_IDX_W;
  localparam int CTRL_LSB = RT_LSB + REG_IDX_W;
  localparam int D_LSB    = CTRL_LSB + CTRL_W;
  localparam int O_LSB    = D_LSB + WORD_W;
  localparam int PC_LSB   = O_LSB + WORD_W;
  localparam int IMIW_W   = PC_LSB + WORD_W;

  function automatic logic [IMIW_W-1:0] imiw_pack(
    input logic [WORD_W-1:0]    pc,
    input logic [WORD_W-1:0]    o,
    input logic [WORD_W-1:0]    d,
    input logic [CTRL_W-1:0]    ctrl,
    input logic [REG_IDX_W-1:0] rt,
    input logic [REG_IDX_W-1:0] rd
  );
    return {pc, o, d, ctrl, rt, rd};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter
// Purpose: counts cycles with inc_i high, sticks at all-ones, cleared by rst only.
// Ports:   clk, rst (sync active-high), inc_i (count enable), cnt_o (count value)
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage_reg.sv
// rtl/pipe_skid_stage_reg.sv - pipeline stage register with 2-entry skid buffer
// Purpose: valid/ready stage register with flush; in_ready is a flop output so
//          back-pressure never chains combinationally between stages.
// Macro:   PIPE_STALL_CNT_EN adds the perf_stall_cnt saturating stall counter.
// Ports:   clk, rst (sync active-high), flush (squash held entries),
//          in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//          (downstream, out_data from main register),
//          perf_stall_cnt (only with PIPE_STALL_CNT_EN)
module pipe_skid_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = IMIW_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, emit;

  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;  // {main_v=0, skid_v=1}: recover
    endcase
    // Flush wins over any transfer this cycle; payload registers keep old contents.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // A flush cycle leaves the count untouched.
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid & ~out_ready & ~flush),
    .cnt_o (perf_stall_cnt)
  );
`else
  wire unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// tb/tb_pipe_skid_stage_reg.sv - directed self-checking bench for pipe_skid_stage_reg
module tb_pipe_skid_stage_reg;

  localparam int                DW   = 109;
  localparam int                CW   = 4;
  localparam logic [DW-1:0]     RSTV = 109'h5A5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [CW-1:0] perf_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage_reg #(
    .DATA_W  (DW),
    .RST_VAL (RSTV),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards settle well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir, input logic [DW-1:0] od);
    check({tag, ".out_valid"}, 128'(out_valid), 128'(ov));
    check({tag, ".in_ready"},  128'(in_ready),  128'(ir));
    check({tag, ".out_data"},  128'(out_data),  128'(od));
  endtask

  initial begin
    logic [DW-1:0] a, b, c, d, e, f;
    a = 109'hAAAA; b = 109'hBBBB; c = 109'hCCCC;
    d = 109'hDDDD; e = 109'hEEEE; f = 109'hF0F0;

    // 1. reset with an upstream payload present
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 109'h1234; out_ready = 1'b0;
    step(); step();
    chk_state("rst", 1'b0, 1'b1, RSTV);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk_state("rst_rel", 1'b0, 1'b1, RSTV);

    // 2. streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, DW'(i));
    end
    in_valid = 1'b0;
    step();
    chk_state("stream_drain", 1'b0, 1'b1, DW'(4));

    // 3. back-pressure fills the skid entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a;
    step();
    chk_state("bp_a", 1'b1, 1'b1, a);
    in_data = b;
    step();
    chk_state("bp_b", 1'b1, 1'b0, a);
    in_data = c;  // offered while full, must be ignored
    step();
    chk_state("bp_hold", 1'b1, 1'b0, a);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_state("bp_pop_a", 1'b1, 1'b1, b);
    step();
    chk_state("bp_pop_b", 1'b0, 1'b1, b);

    // 4. flush in TWO, then flush colliding with accept and emit in ONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a;
    step();
    in_data = b;
    step();
    chk_state("fl_two_pre", 1'b1, 1'b0, a);
    flush = 1'b1; in_data = c;
    step();
    chk_state("fl_two", 1'b0, 1'b1, a);
    flush = 1'b0; in_data = d;
    step();
    chk_state("fl_one_pre", 1'b1, 1'b1, d);
    flush = 1'b1; in_data = e; out_ready = 1'b1;
    step();
    chk_state("fl_acc", 1'b0, 1'b1, d);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk_state("fl_after", 1'b0, 1'b1, d);

    // 5. rst and flush together in ONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = f;
    step();
    chk_state("rf_pre", 1'b1, 1'b1, f);
    rst = 1'b1; flush = 1'b1; in_data = a;
    step();
    chk_state("rf", 1'b0, 1'b1, RSTV);
`ifdef PIPE_STALL_CNT_EN
    check("rf.cnt", 128'(perf_stall_cnt), 128'(0));
`endif
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

`ifdef PIPE_STALL_CNT_EN
    // 6. stall counter saturates and survives flush
    in_valid = 1'b1; in_data = c; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("cnt_start", 128'(perf_stall_cnt), 128'(0));
    for (int i = 0; i < 5; i++) step();
    check("cnt5", 128'(perf_stall_cnt), 128'(5));
    for (int i = 0; i < 15; i++) step();
    check("cnt_sat", 128'(perf_stall_cnt), 128'(15));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("cnt_flush", 128'(perf_stall_cnt), 128'(15));
    check("cnt_flush.ov", 128'(out_valid), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
